// File: rtl/mult_acc_if.sv
`default_nettype none
// ============================================================================
// mult_acc_if : request/response bundle for mult_acc_unit      Rev 1.0
// ============================================================================
interface mult_acc_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  ready, done, err, result, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output ready, done, err, result, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mult_acc_unit.sv
`default_nettype none
// ============================================================================
// mult_acc_unit : iterative shift-add multiplier with HI:LO accumulator.
// Define MULT_ACC_MSUB_EN to enable MSUB/MSUBU.                 Rev 1.0
// ============================================================================
module mult_acc_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic clk,
  input  wire logic rst_n,
  mult_acc_if.slave bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULT   = 3'b001;
  localparam logic [2:0] OP_MULTU  = 3'b010;
  localparam logic [2:0] OP_MADD   = 3'b011;
  localparam logic [2:0] OP_MADDU  = 3'b100;
  localparam logic [2:0] OP_MSUB   = 3'b101;
  localparam logic [2:0] OP_MSUBU  = 3'b110;
  localparam logic [2:0] OP_CLRACC = 3'b111;

`ifdef MULT_ACC_MSUB_EN
  localparam bit MSUB_EN = 1'b1;
`else
  localparam bit MSUB_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [2:0]           op_q;
  logic                 neg_q;
  logic                 err_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     result_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic                 in_signed;
  logic                 in_legal;
  logic                 in_mul;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_acc;

  always_comb begin
    in_signed = (bus.op == OP_MUL) || (bus.op == OP_MULT) ||
                (bus.op == OP_MADD) || (bus.op == OP_MSUB);
    in_legal  = MSUB_EN || !((bus.op == OP_MSUB) || (bus.op == OP_MSUBU));
    in_mul    = in_legal && (bus.op != OP_CLRACC);
  end

  // A W-bit unsigned magnitude covers -2^(W-1): its negation reads back as 2^(W-1).
  assign a_mag  = (in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag  = (in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign w_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                  {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};
  assign w_prod = neg_q ? -prod_q : prod_q;
  assign w_acc  = {hi_q, lo_q};

  assign bus.result = result_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;

  always_comb begin
    state_nxt = state;
    bus.ready = 1'b0;
    bus.done  = 1'b0;
    bus.err   = 1'b0;
    case (state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) state_nxt = in_mul ? CALC : DONE;
      end
      CALC: if (cnt_q == CNT_LAST) state_nxt = ACC;
      ACC:  state_nxt = DONE;
      DONE: begin
        bus.done  = 1'b1;
        bus.err   = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= 3'b000;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.start) begin
          op_q    <= bus.op;
          neg_q   <= in_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          err_q   <= !in_legal;
          mcand_q <= a_mag;
          prod_q  <= {{WIDTH{1'b0}}, b_mag};
          cnt_q   <= '0;
          if (bus.op == OP_CLRACC) begin
            hi_q <= '0;
            lo_q <= '0;
          end
        end
        // Upper half accumulates while the multiplier drains out of the lower half.
        CALC: begin
          prod_q <= {w_sum, prod_q[WIDTH-1:1]};
          cnt_q  <= cnt_q + CW'(1);
        end
        ACC: begin
          result_q <= w_prod[WIDTH-1:0];
          case (op_q)
            OP_MULT, OP_MULTU: {hi_q, lo_q} <= w_prod;
            OP_MADD, OP_MADDU: {hi_q, lo_q} <= w_acc + w_prod;
`ifdef MULT_ACC_MSUB_EN
            OP_MSUB, OP_MSUBU: {hi_q, lo_q} <= w_acc - w_prod;
`endif
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_acc_unit.sv
`default_nettype none
// ============================================================================
// tb_mult_acc_unit : random + directed checks against a behavioural model.
// ============================================================================
module tb_mult_acc_unit;
  localparam int W = 32;

`ifdef MULT_ACC_MSUB_EN
  localparam bit MSUB_EN = 1'b1;
`else
  localparam bit MSUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_acc_if #(.WIDTH(W)) bus ();

  mult_acc_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  bit          chk_en = 1'b0;
  bit          noise = 1'b0;

  // Model: completion edge, pending op, and the architectural state it produces
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  bit          p_err = 1'b0;
  int unsigned m_de = 0;
  logic [2:0]  p_op = 3'd0;
  logic [W-1:0] p_a = '0;
  logic [W-1:0] p_b = '0;
  logic [2*W-1:0] m_acc = '0;
  logic [W-1:0]   m_res = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit legal(input logic [2:0] op);
    return MSUB_EN || !(op == 3'd5 || op == 3'd6);
  endfunction

  function automatic logic [2*W-1:0] product(input logic [2:0] op, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    logic signed [2*W-1:0] sx, sy;
    if (op == 3'd0 || op == 3'd1 || op == 3'd3 || op == 3'd5) begin
      sx = $signed({{W{x[W-1]}}, x});
      sy = $signed({{W{y[W-1]}}, y});
      return sx * sy;
    end
    return {{W{1'b0}}, x} * {{W{1'b0}}, y};
  endfunction

  task automatic m_apply();
    logic [2*W-1:0] p;
    p = product(p_op, p_a, p_b);
    m_done = 1'b1;
    m_err  = p_err;
    if (!p_err) begin
      case (p_op)
        3'd0:       m_res = p[W-1:0];
        3'd1, 3'd2: begin m_res = p[W-1:0]; m_acc = p; end
        3'd3, 3'd4: begin m_res = p[W-1:0]; m_acc = m_acc + p; end
        3'd5, 3'd6: begin m_res = p[W-1:0]; m_acc = m_acc - p; end
        default:    m_acc = '0;
      endcase
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_acc  = '0;
      m_res  = '0;
    end else if (!m_busy) begin
      if (bus.start) begin
        p_op   = bus.op;
        p_a    = bus.a;
        p_b    = bus.b;
        p_err  = !legal(bus.op);
        m_busy = 1'b1;
        m_de   = cyc + ((legal(bus.op) && bus.op != 3'd7) ? W + 1 : 0);
        if (m_de == cyc) m_apply();
      end
    end else if (cyc == m_de) begin
      m_apply();
    end else if (cyc == m_de + 1) begin
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 64'(bus.ready), 64'(!m_busy));
      chk("done", 64'(bus.done), 64'(m_done));
      if (m_done) chk("err", 64'(bus.err), 64'(m_err));
      chk("result", 64'(bus.result), 64'(m_res));
      chk("hi", 64'(bus.hi), 64'(m_acc[2*W-1:W]));
      chk("lo", 64'(bus.lo), 64'(m_acc[W-1:0]));
    end
  end

  int unsigned t_issue;

  task automatic do_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int k;
    for (k = 0; k < 200 && !bus.ready; k++) @(negedge clk);
    if (!bus.ready) chk("ready_timeout", 64'(bus.ready), 64'd1);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = x;
    bus.b     = y;
    t_issue   = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic wait_done(output int lat);
    int k;
    lat = -1;
    if (bus.done) lat = int'(cyc - t_issue);
    for (k = 0; k < 100 && lat < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.done) begin
        lat = int'(cyc - t_issue);
        bus.start = 1'b0;
      end else if (noise) begin
        bus.start = ($urandom_range(0, 2) == 0);
        bus.op    = 3'($urandom);
      end
    end
    bus.start = 1'b0;
    if (lat < 0) chk("done_timeout", 64'(bus.done), 64'd1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int seen;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_acc", {bus.hi, bus.lo}, 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    do_op(3'd0, 32'd6, 32'd7); wait_done(lat);
    chk("mul_lat", 64'(lat), 64'd34);
    chk("mul_result", 64'(bus.result), 64'd42);
    chk("mul_acc", {bus.hi, bus.lo}, 64'd0);
    chk("mul_err", 64'(bus.err), 64'd0);

    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(lat);
    chk("multu_acc", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(lat);
    chk("mult_acc", {bus.hi, bus.lo}, 64'h0000_0000_0000_0001);

    do_op(3'd1, 32'd3, 32'd4); wait_done(lat);
    do_op(3'd3, 32'd5, 32'd6); wait_done(lat);
    chk("madd_acc", {bus.hi, bus.lo}, 64'd42);
    do_op(3'd4, 32'hFFFF_FFFF, 32'd1); wait_done(lat);
    chk("maddu_acc", {bus.hi, bus.lo}, 64'h0000_0001_0000_0029);

    do_op(3'd7, 32'd0, 32'd0); wait_done(lat);
    chk("clr_lat", 64'(lat), 64'd1);
    chk("clr_acc", {bus.hi, bus.lo}, 64'd0);
    do_op(3'd5, 32'h8000_0000, 32'd2); wait_done(lat);
`ifdef MULT_ACC_MSUB_EN
    chk("msub_acc", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);
    chk("msub_err", 64'(bus.err), 64'd0);
`else
    chk("msub_lat", 64'(lat), 64'd1);
    chk("msub_err", 64'(bus.err), 64'd1);
    chk("msub_acc", {bus.hi, bus.lo}, 64'd0);
`endif

    // Start pulses while busy must be dropped
    noise = 1'b1;
    do_op(3'd1, 32'd2, 32'd3); wait_done(lat);
    noise = 1'b0;
    chk("busy_lat", 64'(lat), 64'd34);
    chk("busy_acc", {bus.hi, bus.lo}, 64'd6);

    // Reset in the middle of a MULT, with start held during the reset edge
    do_op(3'd1, 32'd9, 32'd9);
    repeat (9) @(negedge clk);
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.op    = 3'd1;
    @(negedge clk);
    chk("abort_ready", 64'(bus.ready), 64'd1);
    chk("abort_acc", {bus.hi, bus.lo}, 64'd0);
    chk("abort_result", 64'(bus.result), 64'd0);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("abort_no_done", 64'(seen), 64'd0);

    noise = 1'b1;
    for (int i = 0; i < 60; i++) begin
      do_op(3'($urandom), pick(), pick());
      wait_done(lat);
    end
    noise = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
